// File: rtl/comm_slave.sv
// UART command slave: receives 16-bit commands as two 8N1 bytes (high byte first)
// and transmits single-byte responses, with independent RX and TX paths.
module comm_slave #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent
);

    localparam logic [11:0] FULL_LAST = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_TXING} tx_state_t;

    // Synchronizer plus fill flags: no edge is seen until the line has been
    // observed high after reset, so a line held low at release is ignored.
    logic [1:0] rx_sync;
    logic [1:0] sync_fill;
    logic       rx_prev;
    logic       rx_s;
    logic       rx_fall;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync   <= '1;
            sync_fill <= '0;
            rx_prev   <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[0], RX};
            sync_fill <= {sync_fill[0], 1'b1};
            rx_prev   <= sync_fill[1] & rx_s;
        end
    end

    rx_state_t  rx_state, rx_state_n;
    asm_state_t asm_state, asm_state_n;
    logic [11:0] rx_cnt, rx_cnt_n;
    logic [3:0]  rx_bits, rx_bits_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        byte_valid, byte_valid_n;
    logic        byte_err, byte_err_n;
    logic [7:0]  hb, hb_n;
    logic [15:0] cmd_q, cmd_n;
    logic        rdy_q, rdy_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            asm_state  <= ASM_HIGH;
            rx_cnt     <= '0;
            rx_bits    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            hb         <= '0;
            cmd_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            asm_state  <= asm_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_bits    <= rx_bits_n;
            rx_shift   <= rx_shift_n;
            byte_valid <= byte_valid_n;
            byte_err   <= byte_err_n;
            hb         <= hb_n;
            cmd_q      <= cmd_n;
            rdy_q      <= rdy_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        rx_cnt_n     = rx_cnt + 12'd1;
        rx_bits_n    = rx_bits;
        rx_shift_n   = rx_shift;
        byte_valid_n = 1'b0;
        byte_err_n   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n  = '0;
                rx_bits_n = '0;
                if (rx_fall) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bits_n  = rx_bits + 4'd1;
                    if (rx_bits == 4'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_LAST) begin
                    rx_cnt_n     = '0;
                    byte_valid_n = rx_s;
                    byte_err_n   = ~rx_s;
                    rx_state_n   = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase

        // Byte arrives one clock after its stop sample; completion beats clear.
        asm_state_n = asm_state;
        hb_n        = hb;
        cmd_n       = cmd_q;
        rdy_n       = rdy_q;
        if (clr_cmd_rdy) rdy_n = 1'b0;
        if (byte_err) begin
            asm_state_n = ASM_HIGH;
        end else if (byte_valid) begin
            if (asm_state == ASM_HIGH) begin
                hb_n        = rx_shift;
                asm_state_n = ASM_LOW;
            end else begin
                cmd_n       = {hb, rx_shift};
                rdy_n       = 1'b1;
                asm_state_n = ASM_HIGH;
            end
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = rdy_q;

    tx_state_t   tx_state, tx_state_n;
    logic [11:0] tx_cnt, tx_cnt_n;
    logic [3:0]  tx_bits, tx_bits_n;
    logic [9:0]  tx_shift, tx_shift_n;
    logic        busy_q, busy_n;
    logic        sent_q, sent_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
            busy_q   <= busy_n;
            sent_q   <= sent_n;
        end
    end

    // The line is driven straight from bit 0 of the frame register, which idles at all ones.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 12'd1;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        busy_n     = busy_q;
        sent_n     = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n   = '0;
                tx_shift_n = '1;
                busy_n     = 1'b0;
                if (send_resp) begin
                    tx_shift_n = {1'b1, resp, 1'b0};
                    tx_bits_n  = '0;
                    busy_n     = 1'b1;
                    tx_state_n = TX_TXING;
                end
            end
            TX_TXING: begin
                if (tx_cnt == FULL_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_bits == 4'd9) begin
                        tx_shift_n = '1;
                        busy_n     = 1'b0;
                        sent_n     = 1'b1;
                        tx_state_n = TX_IDLE;
                    end else begin
                        tx_shift_n = {1'b1, tx_shift[9:1]};
                        tx_bits_n  = tx_bits + 4'd1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign TX        = tx_shift[0];
    assign tx_busy   = busy_q;
    assign resp_sent = sent_q;

endmodule

// File: tb/tb_comm_slave.sv
// Directed self-checking bench for comm_slave at BAUD_DIV=8: command receive,
// response transmit, glitch, framing error, clear/complete collision and mid-frame reset.
module tb_comm_slave;

    localparam int unsigned BD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        tx_busy;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;

    comm_slave #(.BAUD_DIV(BD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] exp_cmd;
        logic [7:0]  resp;
        logic [9:0]  exp_frame;
    } vec_t;

    vec_t vecs[4];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one frame: start bit at e0+1, each bit BD clocks, then a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BD) @(posedge clk);
            #1;
        end
        RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Stop sample of the low byte lands on edge e79; cmd_rdy must rise on e80.
    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp,
                            input logic clr_on_done, input logic rdy_before);
        send_byte(hi, 1'b1);
        fork
            send_byte(lo, 1'b1);
            begin
                @(posedge clk);
                repeat (79) @(posedge clk);
                #1;
                check_bit("cmd_rdy_before_completion", cmd_rdy, rdy_before);
                if (clr_on_done) clr_cmd_rdy = 1'b1;
                @(posedge clk); #1;
                clr_cmd_rdy = 1'b0;
                check_bit("cmd_rdy_at_completion", cmd_rdy, 1'b1);
                check_word("cmd_value", cmd, exp);
            end
        join
    endtask

    task automatic clear_rdy();
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        check_bit("cmd_rdy_cleared", cmd_rdy, 1'b0);
    endtask

    task automatic send_resp_check(input logic [7:0] r, input logic [9:0] frame, input logic poke);
        @(posedge clk); #1;
        resp = r;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        resp = 8'h00;
        check_bit("tx_busy_after_accept", tx_busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            repeat (4) @(posedge clk);
            #1;
            check_bit("tx_bit", TX, frame[i]);
            if (poke && i == 3) begin
                send_resp = 1'b1;
                resp = 8'h00;
            end
            @(posedge clk); #1;
            send_resp = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            if (i == 9) begin
                check_bit("resp_sent_before_end", resp_sent, 1'b0);
                check_bit("tx_busy_before_end", tx_busy, 1'b1);
            end
            @(posedge clk); #1;
        end
        check_bit("resp_sent_pulse", resp_sent, 1'b1);
        check_bit("tx_busy_dropped", tx_busy, 1'b0);
        check_bit("tx_idle_high", TX, 1'b1);
        @(posedge clk); #1;
        check_bit("resp_sent_one_cycle", resp_sent, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 16'hA53C, 8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 8'hFF, 16'h00FF, 8'h3C, 10'h278};
        vecs[2] = '{8'hFF, 8'h00, 16'hFF00, 8'h00, 10'h200};
        vecs[3] = '{8'h12, 8'h34, 16'h1234, 8'hFF, 10'h3FE};

        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_TX", TX, 1'b1);
        check_word("reset_cmd", cmd, 16'h0000);
        check_bit("reset_cmd_rdy", cmd_rdy, 1'b0);
        check_bit("reset_tx_busy", tx_busy, 1'b0);
        check_bit("reset_resp_sent", resp_sent, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            send_cmd(vecs[v].hi, vecs[v].lo, vecs[v].exp_cmd, 1'b0, 1'b0);
            clear_rdy();
            check_word("cmd_held_after_clear", cmd, vecs[v].exp_cmd);
            send_resp_check(vecs[v].resp, vecs[v].exp_frame, (v == 0));
        end

        // Pending command stays stable across a glitch, then is overwritten.
        send_cmd(8'h55, 8'hAA, 16'h55AA, 1'b0, 1'b0);
        @(posedge clk); #1;
        RX = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_word("cmd_stable_after_glitch", cmd, 16'h55AA);
        check_bit("cmd_rdy_kept_after_glitch", cmd_rdy, 1'b1);
        send_cmd(8'h01, 8'h02, 16'h0102, 1'b0, 1'b1);
        clear_rdy();

        // Framing error discards the byte and realigns the assembler.
        send_byte(8'h11, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check_bit("no_cmd_after_framing_error", cmd_rdy, 1'b0);
        send_cmd(8'h22, 8'h33, 16'h2233, 1'b0, 1'b0);
        clear_rdy();

        // Clear coinciding with completion loses.
        send_cmd(8'hBE, 8'hEF, 16'hBEEF, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check_bit("cmd_rdy_still_set", cmd_rdy, 1'b1);
        clear_rdy();

        // Reset mid-receive and mid-transmit with RX held low across release.
        @(posedge clk); #1;
        RX = 1'b0;
        resp = 8'h5A;
        send_resp = 1'b1;
        @(posedge clk); #1;
        send_resp = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_bit("midreset_TX", TX, 1'b1);
        check_word("midreset_cmd", cmd, 16'h0000);
        check_bit("midreset_cmd_rdy", cmd_rdy, 1'b0);
        check_bit("midreset_tx_busy", tx_busy, 1'b0);
        check_bit("midreset_resp_sent", resp_sent, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        check_bit("no_byte_from_low_release", cmd_rdy, 1'b0);
        check_bit("tx_idle_after_reset", tx_busy, 1'b0);
        send_cmd(8'hC3, 8'h5A, 16'hC35A, 1'b0, 1'b0);
        clear_rdy();
        send_resp_check(8'h3C, 10'h278, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comm_slave.md
COMM_SLAVE -- requirements
Module: comm_slave

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868, clocks per UART bit period (115200 baud at 100 MHz); legal range 8..4095.
REQ-002 SHALL have port clk, input, 1, system clock (100 MHz).
REQ-003 SHALL have port rst_n, input, 1, reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port RX, input, 1, serial line from host, asynchronous to clk, idle high.
REQ-005 SHALL have port TX, output, 1, serial line to host, idle high.
REQ-006 SHALL have port cmd, output, 16, last complete command; high byte is the first byte received.
REQ-007 SHALL have port cmd_rdy, output, 1, high while cmd holds an unconsumed command.
REQ-008 SHALL have port clr_cmd_rdy, input, 1, one-cycle pulse that consumes cmd.
REQ-009 SHALL have port resp, input, 8, response byte, sampled when send_resp is accepted.
REQ-010 SHALL have port send_resp, input, 1, one-cycle request to transmit resp.
REQ-011 SHALL have port tx_busy, output, 1, high from send_resp acceptance until the end of the stop bit.
REQ-012 SHALL have port resp_sent, output, 1, one-cycle pulse at the end of the stop bit.

Function
REQ-013 SHALL synchronize RX through two flops, both preset to 1, before any use.
REQ-014 SHALL use frame format 8N1, LSB first, on both directions.
REQ-015 SHALL use receiver states IDLE, START, DATA, STOP; a falling edge of synchronized RX in IDLE enters START.
REQ-016 SHALL resample in START after BAUD_DIV/2 clocks; if high (glitch) -> IDLE, else -> DATA.
REQ-017 SHALL sample each data bit BAUD_DIV clocks after the previous sample, shifting LSB first; after 8 samples -> STOP.
REQ-018 SHALL sample the stop bit BAUD_DIV clocks after bit 7; if 1, the byte is valid; if 0 (framing error), the byte is discarded and the assembler resets to HIGH; either way -> IDLE.
REQ-019 SHALL run a command assembler with states HIGH and LOW: a valid byte in HIGH loads the internal holding register hb and goes to LOW; a valid byte in LOW writes cmd = {hb, byte} atomically and goes to HIGH.
REQ-020 SHALL set cmd_rdy on the clock after the low byte's stop-bit sample, at the same edge cmd updates.
REQ-021 SHALL keep cmd stable while cmd_rdy=1 except when a new command completes, which overwrites cmd and keeps cmd_rdy=1.
REQ-022 SHALL clear cmd_rdy on clr_cmd_rdy; if clr_cmd_rdy coincides with command completion, set wins.
REQ-023 SHALL use transmitter states IDLE, TXING: send_resp in IDLE latches resp into a 10-bit shift register {1, resp, 0}, asserts tx_busy, and goes to TXING.
REQ-024 SHALL have the TX pin show the start bit from the clock after acceptance, and SHALL shift each bit out after BAUD_DIV clocks, 10 bits total.
REQ-025 SHALL, after the stop bit's BAUD_DIV clocks, pulse resp_sent for one cycle, drop tx_busy on the same edge, drive TX=1, and go to IDLE.
REQ-026 SHALL ignore send_resp while tx_busy=1; no queuing.
REQ-027 SHALL make receiver and transmitter fully independent; full-duplex operation is legal.
REQ-028 SHALL size the bit counters at 4 bits and the baud counters at 12 bits; baud counters reload on every state transition.

Reset
REQ-029 SHALL force, on rst_n low, regardless of activity: TX=1, cmd=16'h0000, cmd_rdy=0, tx_busy=0, resp_sent=0, both FSMs IDLE, assembler HIGH, RX sync flops=1.
REQ-030 SHALL abandon any frame in progress at reset; after release, the receiver waits for a fresh falling edge and ignores the line being low at release until it returns high.

Verification (BAUD_DIV=8)
REQ-031 SHALL be verified so that host sends bytes 8'hA5 then 8'h3C -> cmd=16'hA53C, cmd_rdy=1 exactly one clock after the second stop-bit sample.
REQ-032 SHALL be verified so that send_resp with resp=8'hA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each 8 clocks, then resp_sent one pulse 80 clocks after acceptance and tx_busy low on the same edge.
REQ-033 SHALL be verified so that a 2-clock low glitch on RX -> no byte received, assembler still in HIGH; next command 16'h0102 decodes correctly.
REQ-034 SHALL be verified so that 8'h11 is sent with stop bit 0, then 8'h22 and 8'h33 are sent -> cmd=16'h2233, not 16'h1122.
REQ-035 SHALL be verified so that clr_cmd_rdy asserted on the completion edge of command 16'hBEEF -> cmd_rdy remains 1, and a later clr_cmd_rdy clears it.
REQ-036 SHALL be verified so that rst_n pulsed low mid-transmit and mid-receive -> TX=1 immediately, outputs at reset values, and the next full command and response succeed.
